// File: rtl/mem_b_readback_ctrl_if.sv
// Purpose: bundles the memory B read port and the streamed-word valid/ready port.
// Latency: none, wiring only.
// Backpressure: m_ready from the consumer throttles m_valid/m_data from the controller.
interface mem_b_readback_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              start;
  logic [DATA_W-1:0] ram_data;
  logic [ADDR_W-1:0] addr_b;
  logic              re_b;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              busy;
  logic              done;

  // Controller side
  modport master (
    input  start, ram_data, m_ready,
    output addr_b, re_b, m_data, m_valid, busy, done
  );

  // Environment side: requester, memory B and consumer
  modport slave (
    output start, ram_data, m_ready,
    input  addr_b, re_b, m_data, m_valid, busy, done
  );
endinterface

// File: rtl/mem_b_readback_ctrl.sv
// Purpose: walks memory B from address 0 to DEPTH-1 and streams each word out on valid/ready.
// Latency: start in cycle 0, first read in cycle 1, first m_valid in cycle 3; 1 word/cycle sustained.
// Backpressure: 2-entry buffer; reads are only issued when buffered plus in-flight words leave room.
module mem_b_readback_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
) (
  input logic                  clk,
  input logic                  rst,
  mem_b_readback_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              inflight_q;
  logic [1:0]        occ_q;
  logic [1:0]        occ_d;
  logic [DATA_W-1:0] head_q;     // buffer head, drives m_data directly
  logic [DATA_W-1:0] tail_q;     // second buffer entry
  logic              m_valid_q;
  logic              busy_q;
  logic              done_q;

  logic              pop;
  logic              capture;
  logic              issue;
  logic              drain_done;
  logic [2:0]        pending;

  // Handshake, issue decision and next occupancy
  always_comb begin
    pop        = m_valid_q && bus.m_ready;
    capture    = inflight_q;
    // Words that will sit in the buffer after this edge, before any new read lands.
    pending    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue      = (state_q == READ) && (pending < 3'd2);
    occ_d      = occ_q + {1'b0, capture} - {1'b0, pop};
    // Last read already landed (no in-flight) and the buffer empties at this edge.
    drain_done = (state_q == DRAIN) && !inflight_q && (occ_d == 2'd0);
  end

  // FSM, address counter, 2-entry buffer and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      m_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= issue;
      occ_q      <= occ_d;
      m_valid_q  <= (occ_d != 2'd0);
      done_q     <= 1'b0;

      // Head is the oldest word; a pop shifts the tail forward so FIFO order holds.
      case ({capture, pop})
        2'b11: begin
          if (occ_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= bus.ram_data;
          end else begin
            head_q <= bus.ram_data;
          end
        end
        2'b10: begin
          if (occ_q == 2'd0) head_q <= bus.ram_data;
          else               tail_q <= bus.ram_data;
        end
        2'b01: begin
          if (occ_q == 2'd2) head_q <= tail_q;
        end
        default: ;
      endcase

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= READ;
            busy_q  <= 1'b1;
            addr_q  <= '0;
          end
        end
        READ: begin
          if (issue) begin
            // Address parks on the last word so it never runs past DEPTH-1.
            if (addr_q == LAST_ADDR) state_q <= DRAIN;
            else                     addr_q  <= addr_q + ADDR_ONE;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            addr_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.addr_b  = addr_q;
  assign bus.re_b    = issue;
  assign bus.m_data  = head_q;
  assign bus.m_valid = m_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_mem_b_readback_ctrl.sv
// Purpose: directed checks of the memory B readback controller, DEPTH=4 and DEPTH=1 instances.
// Latency: expected vectors are cycle-exact from the start pulse.
// Backpressure: consumer ready is held low, toggled and held high across the steps.
module tb_mem_b_readback_ctrl;

  logic clk;
  logic rst;

  int total    = 0;
  int bad      = 0;
  int tid      = 0;
  int done_cnt = 0;
  bit mon_on   = 1'b0;

  logic [7:0] got_q[$];
  logic [1:0] addr_q[$];
  logic [7:0] mem_a [4];
  logic [7:0] exp_w [4];
  logic       stall_q   = 1'b0;
  logic [7:0] stall_dat = 8'h00;

  mem_b_readback_ctrl_if #(.DATA_W(8), .ADDR_W(2)) bus_a ();
  mem_b_readback_ctrl_if #(.DATA_W(8), .ADDR_W(2)) bus_b ();

  mem_b_readback_ctrl #(.DATA_W(8), .ADDR_W(2), .DEPTH(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mem_b_readback_ctrl #(.DATA_W(8), .ADDR_W(2), .DEPTH(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory B models: synchronous read, 1-cycle latency
  always @(posedge clk) if (bus_a.re_b) bus_a.ram_data <= mem_a[bus_a.addr_b];
  always @(posedge clk) if (bus_b.re_b) bus_b.ram_data <= (bus_b.addr_b == 2'd0) ? 8'h5A : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Consumer-side monitor for the DEPTH=4 instance
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus_a.m_valid && bus_a.m_ready) got_q.push_back(bus_a.m_data);
      if (bus_a.re_b) addr_q.push_back(bus_a.addr_b);
      if (bus_a.done) done_cnt++;
      chk("occ_le_2", 32'(dut_a.occ_q <= 2'd2), 32'd1);
      if (stall_q) begin
        chk("hold_valid", 32'(bus_a.m_valid), 32'd1);
        chk("hold_data", 32'(bus_a.m_data), 32'(stall_dat));
      end
      stall_q   = bus_a.m_valid && !bus_a.m_ready;
      stall_dat = bus_a.m_data;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    got_q.delete();
    addr_q.delete();
    done_cnt = 0;
  endtask

  // Drive one cycle of inputs, then compare outputs mid-cycle
  task automatic vec(input bit sel, input int c, input logic rdy, input logic st,
                     input logic e_re, input logic [1:0] e_ad, input logic e_mv,
                     input logic [7:0] e_md, input bit ck_md, input logic e_dn, input logic e_by);
    logic       re, mv, dn, by;
    logic [1:0] ad;
    logic [7:0] md;
    if (sel) begin
      bus_b.m_ready = rdy;
      bus_b.start   = st;
    end else begin
      bus_a.m_ready = rdy;
      bus_a.start   = st;
    end
    @(negedge clk);
    re = sel ? bus_b.re_b    : bus_a.re_b;
    ad = sel ? bus_b.addr_b  : bus_a.addr_b;
    mv = sel ? bus_b.m_valid : bus_a.m_valid;
    md = sel ? bus_b.m_data  : bus_a.m_data;
    dn = sel ? bus_b.done    : bus_a.done;
    by = sel ? bus_b.busy    : bus_a.busy;
    chk($sformatf("t%0d c%0d re_b", tid, c), 32'(re), 32'(e_re));
    chk($sformatf("t%0d c%0d addr_b", tid, c), 32'(ad), 32'(e_ad));
    chk($sformatf("t%0d c%0d m_valid", tid, c), 32'(mv), 32'(e_mv));
    if (ck_md) chk($sformatf("t%0d c%0d m_data", tid, c), 32'(md), 32'(e_md));
    chk($sformatf("t%0d c%0d done", tid, c), 32'(dn), 32'(e_dn));
    chk($sformatf("t%0d c%0d busy", tid, c), 32'(by), 32'(e_by));
    @(posedge clk);
    #1;
  endtask

  // Whole-run check: 4 reads at 0..3, words in order, one done, idle afterwards
  task automatic check_run();
    chk($sformatf("t%0d words", tid), 32'(got_q.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < got_q.size()) chk($sformatf("t%0d word%0d", tid, k), 32'(got_q[k]), 32'(exp_w[k]));
    chk($sformatf("t%0d reads", tid), 32'(addr_q.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < addr_q.size()) chk($sformatf("t%0d raddr%0d", tid, k), 32'(addr_q[k]), k);
    chk($sformatf("t%0d done_cnt", tid), done_cnt, 32'd1);
    chk($sformatf("t%0d busy_end", tid), 32'(bus_a.busy), 32'd0);
  endtask

  initial begin
    mem_a[0] = 8'h11; mem_a[1] = 8'h22; mem_a[2] = 8'h33; mem_a[3] = 8'h44;
    exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33; exp_w[3] = 8'h44;
    rst = 1'b0;
    bus_a.start = 1'b0; bus_a.m_ready = 1'b1;
    bus_b.start = 1'b0; bus_b.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    @(negedge clk);
    chk("rst re_b", 32'(bus_a.re_b), 32'd0);
    chk("rst addr_b", 32'(bus_a.addr_b), 32'd0);
    chk("rst m_valid", 32'(bus_a.m_valid), 32'd0);
    chk("rst m_data", 32'(bus_a.m_data), 32'd0);
    chk("rst busy", 32'(bus_a.busy), 32'd0);
    chk("rst done", 32'(bus_a.done), 32'd0);
    chk("rst b m_valid", 32'(bus_b.m_valid), 32'd0);
    chk("rst b busy", 32'(bus_b.busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_on = 1'b1;
    idle(2);

    // 1) full-rate run
    clr(); tid = 1;
    vec(0, 0, 1, 1, 0, 2'd0, 0, 8'h00, 1, 0, 0);
    vec(0, 1, 1, 0, 1, 2'd0, 0, 8'h00, 0, 0, 1);
    vec(0, 2, 1, 0, 1, 2'd1, 0, 8'h00, 0, 0, 1);
    vec(0, 3, 1, 0, 1, 2'd2, 1, 8'h11, 1, 0, 1);
    vec(0, 4, 1, 0, 1, 2'd3, 1, 8'h22, 1, 0, 1);
    vec(0, 5, 1, 0, 0, 2'd3, 1, 8'h33, 1, 0, 1);
    vec(0, 6, 1, 0, 0, 2'd3, 1, 8'h44, 1, 0, 1);
    vec(0, 7, 1, 0, 0, 2'd0, 0, 8'h00, 0, 1, 0);
    vec(0, 8, 1, 0, 0, 2'd0, 0, 8'h00, 0, 0, 0);
    check_run();
    idle(2);

    // 2) consumer stalls c3..c8
    clr(); tid = 2;
    vec(0, 0, 1, 1, 0, 2'd0, 0, 8'h00, 0, 0, 0);
    vec(0, 1, 1, 0, 1, 2'd0, 0, 8'h00, 0, 0, 1);
    vec(0, 2, 1, 0, 1, 2'd1, 0, 8'h00, 0, 0, 1);
    for (int c = 3; c <= 8; c++) vec(0, c, 0, 0, 0, 2'd2, 1, 8'h11, 1, 0, 1);
    vec(0, 9,  1, 0, 1, 2'd2, 1, 8'h11, 1, 0, 1);
    vec(0, 10, 1, 0, 1, 2'd3, 1, 8'h22, 1, 0, 1);
    vec(0, 11, 1, 0, 0, 2'd3, 1, 8'h33, 1, 0, 1);
    vec(0, 12, 1, 0, 0, 2'd3, 1, 8'h44, 1, 0, 1);
    vec(0, 13, 1, 0, 0, 2'd0, 0, 8'h00, 0, 1, 0);
    vec(0, 14, 1, 0, 0, 2'd0, 0, 8'h00, 0, 0, 0);
    check_run();
    idle(2);

    // 3) ready toggling every cycle
    clr(); tid = 3;
    for (int i = 0; i < 40; i++) begin
      bus_a.m_ready = ~i[0];
      bus_a.start   = (i == 0);
      idle(1);
    end
    bus_a.m_ready = 1'b1;
    bus_a.start   = 1'b0;
    check_run();
    idle(2);

    // 4) second start while busy is ignored
    clr(); tid = 4;
    for (int i = 0; i < 20; i++) begin
      bus_a.start = (i == 0) || (i == 2);
      idle(1);
    end
    bus_a.start = 1'b0;
    check_run();
    idle(2);

    // 5) reset mid-run, then a fresh run from address 0
    clr(); tid = 5;
    bus_a.start = 1'b1;
    idle(1);
    bus_a.start = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5 re_b", 32'(bus_a.re_b), 32'd0);
    chk("t5 addr_b", 32'(bus_a.addr_b), 32'd0);
    chk("t5 m_valid", 32'(bus_a.m_valid), 32'd0);
    chk("t5 m_data", 32'(bus_a.m_data), 32'd0);
    chk("t5 busy", 32'(bus_a.busy), 32'd0);
    chk("t5 done", 32'(bus_a.done), 32'd0);
    @(posedge clk);
    #1;
    idle(12);
    chk("t5 no_done", done_cnt, 32'd0);
    clr();
    bus_a.start = 1'b1;
    idle(1);
    bus_a.start = 1'b0;
    idle(15);
    check_run();

    // 6) DEPTH=1 instance, consumer ready from c4
    tid = 6;
    vec(1, 0, 0, 1, 0, 2'd0, 0, 8'h00, 1, 0, 0);
    vec(1, 1, 0, 0, 1, 2'd0, 0, 8'h00, 0, 0, 1);
    vec(1, 2, 0, 0, 0, 2'd0, 0, 8'h00, 0, 0, 1);
    vec(1, 3, 0, 0, 0, 2'd0, 1, 8'h5A, 1, 0, 1);
    vec(1, 4, 1, 0, 0, 2'd0, 1, 8'h5A, 1, 0, 1);
    vec(1, 5, 1, 0, 0, 2'd0, 0, 8'h00, 0, 1, 0);
    vec(1, 6, 1, 0, 0, 2'd0, 0, 8'h00, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
